data_sram_responder: RTL and testbench

Memory-side endpoint of the CPU data SRAM port: it accepts the per-cycle load/store requests issued by the execute stage and returns load data one cycle later, so that the data is on `data_sram_rdata` while the instruction sits in the memory stage. It combines a byte-enabled synchronous data RAM with a small MMIO block: LEDs, switches, a free-running timer, a scratch register and a simulation-done flag. It sits at the top level beside the CPU core and replaces the external SRAM model in simulation and FPGA builds.

---
 rtl/data_sram_responder_pkg.sv | 36 +++
 rtl/data_sram_responder_if.sv | 32 +++
 rtl/data_ram_bank.sv | 42 ++++
 rtl/data_sram_responder.sv | 117 +++++++++++
 tb/tb_data_sram_responder.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data SRAM responder.
//   - MMIO register offsets within the 64 KiB MMIO window
//   - response select type (RAM output register vs MMIO read register)
//   - is_mmio():     address window decode
//   - merge_lanes(): byte-strobe merge of a new word into an old word
package dmem_pkg;

    localparam logic [15:0] LED_OFS     = 16'h0000;
    localparam logic [15:0] SW_OFS      = 16'h0004;
    localparam logic [15:0] TIMER_OFS   = 16'h0008;
    localparam logic [15:0] SCRATCH_OFS = 16'h000C;
    localparam logic [15:0] SIMDONE_OFS = 16'h0010;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hBFAF_0000;

    typedef enum logic {SEL_RAM, SEL_MMIO} resp_sel_t;

    // The upper halves match exactly when the XOR of the two addresses
    // has no bit set above bit 15.
    function automatic logic is_mmio(input logic [31:0] addr,
                                     input logic [31:0] base = MMIO_BASE_DEFAULT);
        return (addr ^ base) < 32'h0001_0000;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  we);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) result[8*i +: 8] = new_word[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// CPU data SRAM port.
//   data_sram_en     request valid this cycle
//   data_sram_we     byte write strobes, 0 = read
//   data_sram_addr   byte address
//   data_sram_wdata  lane-aligned store data
//   data_sram_rdata  response for the previous cycle's request
// master = CPU side, slave = memory side.
interface data_sram_responder_if;

    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en,
        output data_sram_we,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_we,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );

endinterface

// File: rtl/data_ram_bank.sv
// Byte-enabled, read-first synchronous RAM of 2**DEPTH_LOG2 32-bit words.
//   clk    clock
//   en     access enable; the read register only updates when en is high
//   we     per-lane write strobes (qualified by en)
//   addr   word index
//   wdata  write data
//   rdata  registered read data (contents before the same-edge write)
// Each byte lane is its own array so every lane maps onto a plain
// single-port block RAM with registered output and no reset.
module data_ram_bank #(
    parameter int DEPTH_LOG2 = 14
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [0:DEPTH-1];
            logic [7:0] rd_reg;

            always_ff @(posedge clk) begin
                if (en) begin
                    rd_reg <= mem[addr];
                    if (we[gi]) begin
                        mem[addr] <= wdata[8*gi +: 8];
                    end
                end
            end

            assign rdata[8*gi +: 8] = rd_reg;
        end
    endgenerate

endmodule

// File: rtl/data_sram_responder.sv
// Memory-side endpoint of the CPU data SRAM port: data RAM plus a small
// MMIO block (LED, SWITCH, TIMER, SCRATCH, SIM_DONE). Responses arrive one
// cycle after the request, read-first, no wait states.
//   clk       clock
//   reset     asynchronous active-high reset
//   sram      data SRAM port (slave side)
//   switches  board switches, sampled when read
//   led       LED register
//   sim_done  sticky flag set by any write to SIM_DONE
module data_sram_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 14,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    data_sram_responder_if.slave  sram,
    input  logic [15:0]           switches,
    output logic [15:0]           led,
    output logic                  sim_done
);

    logic        req;
    logic        mmio_hit;
    logic        mmio_wr;
    logic        ram_en;
    logic [15:0] ofs;
    logic [31:0] ram_rdata;

    logic [15:0] led_reg;
    logic [31:0] timer_reg;
    logic [31:0] timer_next;
    logic [31:0] scratch_reg;
    logic        sim_done_reg;
    logic [31:0] mmio_rdata_reg;
    logic [31:0] mmio_rdata_next;
    resp_sel_t   sel_reg;

    assign req      = sram.data_sram_en;
    assign mmio_hit = is_mmio(sram.data_sram_addr, MMIO_BASE);
    assign ofs      = sram.data_sram_addr[15:0];
    assign mmio_wr  = req && mmio_hit && (sram.data_sram_we != 4'h0);
    // RAM has no reset, so requests made while reset is high are gated here.
    assign ram_en   = req && !mmio_hit && !reset;

    data_ram_bank #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (sram.data_sram_we),
        .addr  (sram.data_sram_addr[DEPTH_LOG2+1:2]),
        .wdata (sram.data_sram_wdata),
        .rdata (ram_rdata)
    );

    // MMIO read value from the current (pre-edge) register state.
    always_comb begin
        mmio_rdata_next = 32'h0;
        case (ofs)
            LED_OFS:     mmio_rdata_next = {16'h0, led_reg};
            SW_OFS:      mmio_rdata_next = {16'h0, switches};
            TIMER_OFS:   mmio_rdata_next = timer_reg;
            SCRATCH_OFS: mmio_rdata_next = scratch_reg;
            SIMDONE_OFS: mmio_rdata_next = {31'h0, sim_done_reg};
            default:     mmio_rdata_next = 32'h0;
        endcase
    end

    // Written TIMER lanes override the incremented value; unwritten lanes
    // still advance.
    always_comb begin
        timer_next = timer_reg + 32'd1;
        if (mmio_wr && ofs == TIMER_OFS) begin
            timer_next = merge_lanes(timer_next, sram.data_sram_wdata, sram.data_sram_we);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_reg        <= 16'h0;
            timer_reg      <= 32'h0;
            scratch_reg    <= 32'h0;
            sim_done_reg   <= 1'b0;
            mmio_rdata_reg <= 32'h0;
            // Pointing the mux at the cleared MMIO register makes rdata
            // read 0 during and after reset without resetting the RAM.
            sel_reg        <= SEL_MMIO;
        end else begin
            timer_reg <= timer_next;
            if (req) begin
                sel_reg <= mmio_hit ? SEL_MMIO : SEL_RAM;
                if (mmio_hit) begin
                    mmio_rdata_reg <= mmio_rdata_next;
                end
            end
            if (mmio_wr) begin
                case (ofs)
                    LED_OFS: begin
                        if (sram.data_sram_we[0]) led_reg[7:0]  <= sram.data_sram_wdata[7:0];
                        if (sram.data_sram_we[1]) led_reg[15:8] <= sram.data_sram_wdata[15:8];
                    end
                    SCRATCH_OFS: scratch_reg <= merge_lanes(scratch_reg, sram.data_sram_wdata,
                                                            sram.data_sram_we);
                    SIMDONE_OFS: sim_done_reg <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign sram.data_sram_rdata = (sel_reg == SEL_RAM) ? ram_rdata : mmio_rdata_reg;
    assign led                  = led_reg;
    assign sim_done             = sim_done_reg;

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: directed cases for each
// feature followed by randomized traffic, all checked against a
// transaction-level model kept in this file.
module tb_data_sram_responder;

    logic        clk;
    logic        reset;
    logic [15:0] switches;
    logic [15:0] led;
    logic        sim_done;

    data_sram_responder_if bus ();

    data_sram_responder dut (
        .clk      (clk),
        .reset    (reset),
        .sram     (bus.slave),
        .switches (switches),
        .led      (led),
        .sim_done (sim_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared = 0;
    int n_mismatch = 0;
    int n_cyc      = 0;

    // Reference model state
    logic [31:0] m_ram [int];
    logic [15:0] m_led;
    logic [31:0] m_timer;
    logic [31:0] m_scratch;
    bit          m_done;
    logic [31:0] m_rdata;
    bit          m_known;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_led     = 16'h0;
        m_timer   = 32'h0;
        m_scratch = 32'h0;
        m_done    = 1'b0;
        m_rdata   = 32'h0;
        m_known   = 1'b1;
    endtask

    // One clock cycle: called at a falling edge, drives the request,
    // predicts the response, checks after the rising edge, and returns at
    // the next falling edge.
    task automatic cycle(input bit en, input logic [3:0] we, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] got);
        bit          mmio;
        int          idx;
        logic [31:0] resp;
        bit          known;
        logic [31:0] t_next;
        logic [31:0] w;

        bus.data_sram_en    = en;
        bus.data_sram_we    = we;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;

        mmio   = (addr[31:16] == 16'hBFAF);
        idx    = int'(addr[15:2]);
        resp   = m_rdata;
        known  = m_known;
        t_next = m_timer + 32'd1;

        if (en) begin
            if (mmio) begin
                known = 1'b1;
                case (addr[15:0])
                    16'h0000: resp = {16'h0, m_led};
                    16'h0004: resp = {16'h0, switches};
                    16'h0008: resp = m_timer;
                    16'h000C: resp = m_scratch;
                    16'h0010: resp = {31'h0, m_done};
                    default:  resp = 32'h0;
                endcase
                if (we != 4'h0) begin
                    for (int i = 0; i < 4; i++) begin
                        if (we[i]) begin
                            case (addr[15:0])
                                16'h0000: if (i < 2) m_led[8*i +: 8] = wdata[8*i +: 8];
                                16'h0008: t_next[8*i +: 8] = wdata[8*i +: 8];
                                16'h000C: m_scratch[8*i +: 8] = wdata[8*i +: 8];
                                default: ;
                            endcase
                        end
                    end
                    if (addr[15:0] == 16'h0010) m_done = 1'b1;
                end
            end else begin
                known = m_ram.exists(idx);
                if (known) resp = m_ram[idx];
                if (we != 4'h0 && (known || we == 4'hF)) begin
                    w = known ? m_ram[idx] : 32'h0;
                    for (int i = 0; i < 4; i++) begin
                        if (we[i]) w[8*i +: 8] = wdata[8*i +: 8];
                    end
                    m_ram[idx] = w;
                end
            end
        end

        @(posedge clk);
        #1;
        n_cyc++;
        m_timer = t_next;
        m_rdata = resp;
        m_known = known;
        got     = bus.data_sram_rdata;

        if (m_known) check_value("rdata", got, m_rdata);
        check_value("led", {16'h0, led}, {16'h0, m_led});
        check_value("sim_done", {31'h0, sim_done}, {31'h0, m_done});
        if (en) begin
            $display("txn t=%0t we=%h addr=%h wdata=%h sw=%h -> rdata=%h", $time, we, addr, wdata,
                     switches, got);
        end
        @(negedge clk);
    endtask

    localparam logic [31:0] MB = 32'hBFAF_0000;

    logic [31:0] got;
    logic [31:0] t1;
    logic [31:0] t2;

    initial begin
        reset               = 1'b1;
        switches            = 16'h0;
        bus.data_sram_en    = 1'b0;
        bus.data_sram_we    = 4'h0;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;
        repeat (3) @(negedge clk);

        // Reset state
        check_value("reset_rdata", bus.data_sram_rdata, 32'h0);
        check_value("reset_led", {16'h0, led}, 32'h0);
        check_value("reset_sim_done", {31'h0, sim_done}, 32'h0);
        reset = 1'b0;
        model_reset();
        n_cyc = 0;

        // RAM write then read
        cycle(1, 4'hF, 32'h0000_0100, 32'h1234_5678, got);
        cycle(1, 4'h0, 32'h0000_0100, 32'h0, got);
        check_value("ram_wr_rd", got, 32'h1234_5678);

        // Byte strobes and read-first
        cycle(1, 4'b0010, 32'h0000_0100, 32'h0000_AB00, got);
        check_value("read_first", got, 32'h1234_5678);
        cycle(1, 4'h0, 32'h0000_0100, 32'h0, got);
        check_value("byte_strobe", got, 32'h1234_AB78);

        // TIMER increment and wrap
        while (n_cyc < 9) cycle(0, 4'h0, 32'h0, 32'h0, got);
        cycle(1, 4'h0, MB | 32'h8, 32'h0, t1);
        cycle(1, 4'h0, MB | 32'h8, 32'h0, t2);
        check_value("timer_step", t2 - t1, 32'd1);
        cycle(1, 4'hF, MB | 32'h8, 32'hFFFF_FFFE, got);
        cycle(0, 4'h0, 32'h0, 32'h0, got);
        cycle(0, 4'h0, 32'h0, 32'h0, got);
        cycle(1, 4'h0, MB | 32'h8, 32'h0, got);
        check_value("timer_wrap", got, 32'h0);

        // Aliasing and unmapped MMIO
        cycle(1, 4'hF, 32'h0004_0000, 32'hDEAD_BEEF, got);
        cycle(1, 4'h0, 32'h0000_0000, 32'h0, got);
        check_value("alias", got, 32'hDEAD_BEEF);
        cycle(1, 4'h0, MB | 32'h20, 32'h0, got);
        check_value("unmapped", got, 32'h0);

        // LED, SWITCH, SIM_DONE
        cycle(1, 4'hF, MB | 32'h0, 32'h0000_A5A5, got);
        check_value("led_write", {16'h0, led}, 32'h0000_A5A5);
        switches = 16'h00F0;
        cycle(1, 4'h0, MB | 32'h4, 32'h0, got);
        check_value("switch_read", got, 32'h0000_00F0);
        cycle(1, 4'h1, MB | 32'h10, 32'h1, got);
        check_value("sim_done_set", {31'h0, sim_done}, 32'h1);
        cycle(0, 4'h0, 32'h0, 32'h0, got);
        cycle(1, 4'h0, MB | 32'h10, 32'h0, got);
        check_value("sim_done_sticky", got, 32'h1);

        // Reset in the middle of an LED write
        bus.data_sram_en    = 1'b1;
        bus.data_sram_we    = 4'hF;
        bus.data_sram_addr  = MB | 32'h0;
        bus.data_sram_wdata = 32'h0000_1234;
        #2;
        reset = 1'b1;
        #1;
        check_value("rst_async_led", {16'h0, led}, 32'h0);
        check_value("rst_async_rdata", bus.data_sram_rdata, 32'h0);
        check_value("rst_async_done", {31'h0, sim_done}, 32'h0);
        @(posedge clk);
        #1;
        check_value("rst_write_dropped", {16'h0, led}, 32'h0);
        check_value("rst_rdata_held", bus.data_sram_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cycle(1, 4'h3, MB | 32'h0, 32'h0000_3C3C, got);
        check_value("post_rst_no_resp", got, 32'h0);
        cycle(1, 4'h0, MB | 32'h0, 32'h0, got);
        check_value("post_rst_led", got, 32'h0000_3C3C);

        // Randomized traffic over a small initialized RAM region and all MMIO offsets
        for (int k = 0; k < 16; k++) begin
            cycle(1, 4'hF, 32'h0000_0100 + 32'(4 * k), $urandom, got);
        end
        for (int n = 0; n < 400; n++) begin
            bit          en;
            logic [3:0]  we;
            logic [31:0] addr;
            logic [15:0] mofs [7];
            mofs[0] = 16'h0000; mofs[1] = 16'h0004; mofs[2] = 16'h0008; mofs[3] = 16'h000C;
            mofs[4] = 16'h0010; mofs[5] = 16'h0014; mofs[6] = 16'h0020;
            switches = 16'($urandom);
            en = ($urandom_range(0, 4) != 0);
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 2) == 0) begin
                addr = MB | {16'h0, mofs[$urandom_range(0, 6)]};
            end else begin
                addr = ($urandom & 32'h7FFF_0000) | (32'h0000_0100 + 32'(4 * $urandom_range(0, 15)))
                       | 32'($urandom_range(0, 3));
            end
            cycle(en, we, addr, $urandom, got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
